// File: rtl/in_mem_rd_sched_pkg.sv
// Shared types for the input-memory read scheduler: requester indices,
// FSM encoding, the response tag, and the round-robin pick helper.
package in_mem_rd_sched_pkg;

  localparam int NUM_REQ = 3;
  localparam int REQ_C1  = 0;
  localparam int REQ_C   = 1;
  localparam int REQ_MP  = 2;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } rd_state_t;

  typedef struct packed {
    logic       valid;
    logic [1:0] id;
    logic       last;
  } rsp_tag_t;

  // First candidate in the order last+1, last+2, last+3 (mod NUM_REQ).
  function automatic logic [1:0] rr_pick(input logic [1:0]         last,
                                         input logic [NUM_REQ-1:0] cand);
    logic [1:0] idx;
    logic [1:0] pick;
    logic       found;
    idx   = last;
    pick  = last;
    found = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = (idx == 2'd2) ? 2'd0 : idx + 2'd1;
      if (!found && cand[idx]) begin
        pick  = idx;
        found = 1'b1;
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/in_mem_rd_lat_pipe.sv
// Response-tag delay line matching the BRAM read latency; a flush
// invalidates every stage in one edge.
module in_mem_rd_lat_pipe
  import in_mem_rd_sched_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic     i_clk,
  input  logic     i_rst_n,
  input  logic     i_flush,
  input  rsp_tag_t i_tag,
  output rsp_tag_t o_tag,
  output logic     o_any_valid
);

  rsp_tag_t r_stage [DEPTH];

  always_ff @(posedge i_clk) begin
    if (!i_rst_n || i_flush) begin
      for (int i = 0; i < DEPTH; i++) r_stage[i] <= '0;
    end else begin
      r_stage[0] <= i_tag;
      for (int i = 1; i < DEPTH; i++) r_stage[i] <= r_stage[i-1];
    end
  end

  assign o_tag = r_stage[DEPTH-1];

  always_comb begin
    o_any_valid = 1'b0;
    for (int i = 0; i < DEPTH; i++) o_any_valid |= r_stage[i].valid;
  end

endmodule

// File: rtl/in_mem_rd_sched.sv
// Round-robin whole-burst scheduler for the input-memory read port.
// Optional counters: define INMEM_RD_PERF_EN for perf_beats/perf_stall/perf_clr.
//   state    | meaning
//   ST_IDLE  | arbitrate among req_valid & req_en_mask, no beat accepted
//   ST_BURST | granted requester streams beats until req_last
module in_mem_rd_sched
  import in_mem_rd_sched_pkg::*;
#(
  parameter int AXI_HP_BIT = 64,
  parameter int ADDR_WIDTH = 14,
  parameter int RD_LATENCY = 2
) (
  input  logic                                i_clk,
  input  logic                                i_rst_n,
  input  logic [NUM_REQ-1:0]                  i_req_en_mask,
  input  logic                                i_abort,
  input  logic [NUM_REQ-1:0]                  i_req_valid,
  input  logic [NUM_REQ*(ADDR_WIDTH+1)-1:0]   i_req_addr,
  input  logic [NUM_REQ-1:0]                  i_req_last,
  output logic [NUM_REQ-1:0]                  o_req_ready,
  output logic [NUM_REQ-1:0]                  o_rsp_valid,
  output logic [NUM_REQ-1:0]                  o_rsp_last,
  output logic [AXI_HP_BIT-1:0]               o_rsp_data,
  output logic                                o_mem_rd_en,
  output logic [ADDR_WIDTH:0]                 o_mem_rd_addr,
  input  logic [AXI_HP_BIT-1:0]               i_mem_rd_data,
  output logic                                o_busy
`ifdef INMEM_RD_PERF_EN
  ,
  input  logic                                i_perf_clr,
  output logic [NUM_REQ*32-1:0]               o_perf_beats,
  output logic [NUM_REQ*32-1:0]               o_perf_stall
`endif
);

  localparam int AW = ADDR_WIDTH + 1;

  rd_state_t          r_state, w_state_nxt;
  logic [1:0]         r_grant, w_grant_nxt;
  logic [1:0]         r_last_grant, w_last_grant_nxt;
  logic [NUM_REQ-1:0] w_cand;
  logic [NUM_REQ-1:0] w_ready;
  logic               w_beat;
  logic [AW-1:0]      w_addr_slice [NUM_REQ];
  logic [AW-1:0]      r_mem_rd_addr;
  rsp_tag_t           r_issue_tag;
  rsp_tag_t           w_out_tag;
  logic               w_pipe_busy;

  assign w_cand = i_req_valid & i_req_en_mask;

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) w_addr_slice[i] = i_req_addr[i*AW +: AW];
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state      <= ST_IDLE;
      r_grant      <= '0;
      r_last_grant <= 2'(REQ_MP);
    end else begin
      r_state      <= w_state_nxt;
      r_grant      <= w_grant_nxt;
      r_last_grant <= w_last_grant_nxt;
    end
  end

  // Abort wins over any beat: ready stays low so nothing is accepted.
  always_comb begin
    w_state_nxt      = r_state;
    w_grant_nxt      = r_grant;
    w_last_grant_nxt = r_last_grant;
    w_ready          = '0;
    w_beat           = 1'b0;
    if (i_abort) begin
      w_state_nxt = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (|w_cand) begin
            w_grant_nxt = rr_pick(r_last_grant, w_cand);
            w_state_nxt = ST_BURST;
          end
        end
        ST_BURST: begin
          w_ready[r_grant] = 1'b1;
          w_beat           = i_req_valid[r_grant];
          if (w_beat && i_req_last[r_grant]) begin
            w_last_grant_nxt = r_grant;
            w_state_nxt      = ST_IDLE;
          end
        end
        default: w_state_nxt = ST_IDLE;
      endcase
    end
  end

  assign o_req_ready = w_ready;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_issue_tag   <= '0;
      r_mem_rd_addr <= '0;
    end else begin
      r_issue_tag <= '0;
      if (w_beat) begin
        r_issue_tag   <= '{valid: 1'b1, id: r_grant, last: i_req_last[r_grant]};
        r_mem_rd_addr <= w_addr_slice[r_grant];
      end
    end
  end

  assign o_mem_rd_en   = r_issue_tag.valid;
  assign o_mem_rd_addr = r_mem_rd_addr;

  in_mem_rd_lat_pipe #(
    .DEPTH(RD_LATENCY)
  ) u_lat_pipe (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_flush    (i_abort),
    .i_tag      (r_issue_tag),
    .o_tag      (w_out_tag),
    .o_any_valid(w_pipe_busy)
  );

  always_comb begin
    o_rsp_valid = '0;
    o_rsp_last  = '0;
    if (w_out_tag.valid) begin
      o_rsp_valid[w_out_tag.id] = 1'b1;
      o_rsp_last[w_out_tag.id]  = w_out_tag.last;
    end
  end

  assign o_rsp_data = i_mem_rd_data;
  assign o_busy     = (r_state == ST_BURST) | r_issue_tag.valid | w_pipe_busy;

`ifdef INMEM_RD_PERF_EN
  logic [31:0] r_perf_beats [NUM_REQ];
  logic [31:0] r_perf_stall [NUM_REQ];

  always_ff @(posedge i_clk) begin
    if (!i_rst_n || i_perf_clr) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        r_perf_beats[i] <= '0;
        r_perf_stall[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (w_ready[i] && i_req_valid[i] && (r_perf_beats[i] != '1))
          r_perf_beats[i] <= r_perf_beats[i] + 32'd1;
        if (w_cand[i] && !w_ready[i] && (r_perf_stall[i] != '1))
          r_perf_stall[i] <= r_perf_stall[i] + 32'd1;
      end
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      o_perf_beats[i*32 +: 32] = r_perf_beats[i];
      o_perf_stall[i*32 +: 32] = r_perf_stall[i];
    end
  end
`endif

endmodule

// File: tb/tb_in_mem_rd_sched.sv
// Scoreboard bench for in_mem_rd_sched: drivers push expected reads and
// responses, a negedge monitor pops and compares them.
module tb_in_mem_rd_sched;

  localparam int AW  = 15;
  localparam int LAT = 2;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk  = 0;
  int n_pass = 0;

  function automatic void chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", nm, got, exp);
  endfunction

  function automatic logic [63:0] mword(input logic [AW-1:0] a);
    return {a, ~a, 34'h2_5A5A_A5A5};
  endfunction

  // ---------------- DUT A (default latency) ----------------
  logic [2:0]      mask;
  logic            abort;
  logic            tv [3];
  logic [AW-1:0]   ta [3];
  logic            tl [3];
  logic [2:0]      req_valid, req_last, req_ready, rsp_valid, rsp_last;
  logic [3*AW-1:0] req_addr;
  logic [63:0]     rsp_data, mem_rd_data;
  logic            mem_rd_en, busy;
  logic [AW-1:0]   mem_rd_addr;
  logic [AW-1:0]   mp_a [LAT];

  assign req_valid = {tv[2], tv[1], tv[0]};
  assign req_last  = {tl[2], tl[1], tl[0]};
  assign req_addr  = {ta[2], ta[1], ta[0]};

  in_mem_rd_sched dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_req_en_mask(mask), .i_abort(abort),
    .i_req_valid(req_valid), .i_req_addr(req_addr), .i_req_last(req_last),
    .o_req_ready(req_ready), .o_rsp_valid(rsp_valid), .o_rsp_last(rsp_last),
    .o_rsp_data(rsp_data), .o_mem_rd_en(mem_rd_en), .o_mem_rd_addr(mem_rd_addr),
    .i_mem_rd_data(mem_rd_data), .o_busy(busy)
  );

  always @(posedge clk) begin
    mp_a[0] <= mem_rd_addr;
    for (int k = 1; k < LAT; k++) mp_a[k] <= mp_a[k-1];
  end
  assign mem_rd_data = mword(mp_a[LAT-1]);

  // ---------------- DUT B (latency 1) ----------------
  logic [2:0]      b_valid, b_last, b_ready, b_rsp_valid, b_rsp_last;
  logic [3*AW-1:0] b_addr;
  logic [63:0]     b_rsp_data, b_mem_rd_data;
  logic            b_mem_rd_en, b_busy;
  logic [AW-1:0]   b_mem_rd_addr, b_mp;

  in_mem_rd_sched #(.RD_LATENCY(1)) dut_l1 (
    .i_clk(clk), .i_rst_n(rst_n), .i_req_en_mask(3'b111), .i_abort(1'b0),
    .i_req_valid(b_valid), .i_req_addr(b_addr), .i_req_last(b_last),
    .o_req_ready(b_ready), .o_rsp_valid(b_rsp_valid), .o_rsp_last(b_rsp_last),
    .o_rsp_data(b_rsp_data), .o_mem_rd_en(b_mem_rd_en), .o_mem_rd_addr(b_mem_rd_addr),
    .i_mem_rd_data(b_mem_rd_data), .o_busy(b_busy)
  );

  always @(posedge clk) b_mp <= b_mem_rd_addr;
  assign b_mem_rd_data = mword(b_mp);

  // ---------------- scoreboard ----------------
  typedef struct { int id; logic last; logic [AW-1:0] addr; int due; } exp_t;
  typedef struct { int r; int first; int last; } burst_t;
  exp_t   iss_q [$];
  exp_t   rsp_q [$];
  burst_t blog  [$];

  initial begin
    exp_t e;
    logic [2:0] oh;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        chk("ready_onehot0", 64'($onehot0(req_ready)), 64'd1);
        if (mem_rd_en) begin
          if (iss_q.size() == 0) begin
            n_chk++;
            $display("FAIL unexpected_rd_en: got read of %0h, expected no read", mem_rd_addr);
          end else begin
            e = iss_q.pop_front();
            chk("rd_addr", 64'(mem_rd_addr), 64'(e.addr));
            chk("rd_cycle", 64'(cyc), 64'(e.due));
          end
        end
        if (rsp_valid != 3'b000) begin
          if (rsp_q.size() == 0) begin
            n_chk++;
            $display("FAIL unexpected_rsp: got rsp_valid %b, expected none", rsp_valid);
          end else begin
            e  = rsp_q.pop_front();
            oh = 3'b001 << e.id;
            chk("rsp_valid", 64'(rsp_valid), 64'(oh));
            chk("rsp_last", 64'(rsp_last), e.last ? 64'(oh) : 64'd0);
            chk("rsp_data", rsp_data, mword(e.addr));
            chk("rsp_cycle", 64'(cyc), 64'(e.due));
          end
        end
      end
    end
  end

  task automatic wait_ready(input int r, output int t, output bit ok);
    t = 0;
    do begin @(negedge clk); t++; end while (!req_ready[r] && t < 100);
    ok = req_ready[r];
    if (!ok) begin
      n_chk++;
      $display("FAIL accept_timeout_r%0d: got no req_ready after %0d cycles, expected ready", r, t);
    end
  endtask

  task automatic push_beat(input int r, input logic [AW-1:0] a, input logic last, input int acc);
    iss_q.push_back('{id: r, last: last, addr: a, due: acc});
    rsp_q.push_back('{id: r, last: last, addr: a, due: acc + LAT});
  endtask

  task automatic drive_burst(input int r, input logic [AW-1:0] base, input int n,
                             input int gap_at, output int first_wait);
    int t, acc, first_acc;
    bit ok;
    first_wait = 0; first_acc = 0; acc = 0;
    for (int b = 0; b < n; b++) begin
      if (b == gap_at) begin
        tv[r] = 1'b0;
        for (int g = 0; g < 3; g++) begin
          @(negedge clk);
          chk("stall_grant_hold", 64'(req_ready), 64'd1 << r);
          if (g > 0) chk("stall_no_rd_en", 64'(mem_rd_en), 64'd0);
          @(posedge clk); #1;
        end
      end
      tv[r] = 1'b1; ta[r] = base + AW'(b); tl[r] = (b == n - 1);
      wait_ready(r, t, ok);
      if (!ok) begin tv[r] = 1'b0; tl[r] = 1'b0; return; end
      acc = cyc + 1;
      if (b == 0) begin first_wait = t; first_acc = acc; end
      push_beat(r, ta[r], tl[r], acc);
      @(posedge clk); #1;
    end
    tv[r] = 1'b0; tl[r] = 1'b0;
    blog.push_back('{r: r, first: first_acc, last: acc});
  endtask

  task automatic drain();
    int t = 0;
    while ((iss_q.size() != 0 || rsp_q.size() != 0) && t < 50) begin @(negedge clk); t++; end
    @(negedge clk);
    chk("drain_rsp_q_empty", 64'(rsp_q.size()), 64'd0);
    chk("drain_busy", 64'(busy), 64'd0);
  endtask

  task automatic do_reset(input bit check);
    for (int i = 0; i < 3; i++) begin tv[i] = 1'b0; ta[i] = '0; tl[i] = 1'b0; end
    abort = 1'b0; mask = 3'b111;
    b_valid = '0; b_last = '0; b_addr = '0;
    rst_n = 1'b0;
    @(posedge clk); @(negedge clk);
    if (check) begin
      chk("rst_ready", 64'(req_ready), 64'd0);
      chk("rst_rd_en", 64'(mem_rd_en), 64'd0);
      chk("rst_rd_addr", 64'(mem_rd_addr), 64'd0);
      chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
      chk("rst_rsp_last", 64'(rsp_last), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    iss_q.delete(); rsp_q.delete(); blog.delete();
  endtask

  task automatic check_order(input string nm, input int exp_r [], input bit chk_gap);
    chk({nm, "_count"}, 64'(blog.size()), 64'(exp_r.size()));
    for (int k = 0; k < exp_r.size() && k < blog.size(); k++) begin
      chk({nm, "_grant"}, 64'(blog[k].r), 64'(exp_r[k]));
      if (chk_gap && k > 0) chk({nm, "_bubble"}, 64'(blog[k].first - blog[k-1].last), 64'd2);
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got no finish by time limit, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int fw, t, acc, seen1, fi, fr;
    bit ok;
    do_reset(1'b1);

    // single requester 1, 4-beat burst 0x0010..0x0013
    drive_burst(1, 15'h0010, 4, -1, fw);
    chk("t1_ready_latency", 64'(fw), 64'd2);
    drain();
    check_order("t1", '{1}, 1'b0);

    // all three requesting, 2-beat bursts, round robin from 0
    do_reset(1'b0);
    fork
      begin int w; drive_burst(0, 15'h0100, 2, -1, w); drive_burst(0, 15'h0102, 2, -1, w); end
      begin int w; drive_burst(1, 15'h0110, 2, -1, w); drive_burst(1, 15'h0112, 2, -1, w); end
      begin int w; drive_burst(2, 15'h0120, 2, -1, w); drive_burst(2, 15'h0122, 2, -1, w); end
    join
    drain();
    check_order("t2", '{0, 1, 2, 0, 1, 2}, 1'b1);

    // requester 1 masked off while requesting
    do_reset(1'b0);
    mask = 3'b101;
    tv[1] = 1'b1; ta[1] = 15'h0200; tl[1] = 1'b1;
    seen1 = 0;
    fork
      begin int w; drive_burst(0, 15'h0210, 2, -1, w); drive_burst(0, 15'h0212, 2, -1, w); end
      begin int w; drive_burst(2, 15'h0220, 2, -1, w); drive_burst(2, 15'h0222, 2, -1, w); end
      for (int i = 0; i < 40; i++) begin @(negedge clk); if (req_ready[1]) seen1++; end
    join
    tv[1] = 1'b0; tl[1] = 1'b0;
    drain();
    mask = 3'b111;
    chk("t3_masked_ready_cycles", 64'(seen1), 64'd0);
    check_order("t3", '{0, 2, 0, 2}, 1'b1);

    // requester 0 stalls 3 cycles mid-burst while 1 and 2 wait
    do_reset(1'b0);
    tv[1] = 1'b1; ta[1] = 15'h0310; tl[1] = 1'b1;
    tv[2] = 1'b1; ta[2] = 15'h0320; tl[2] = 1'b1;
    drive_burst(0, 15'h0300, 4, 2, fw);
    tv[1] = 1'b0; tl[1] = 1'b0; tv[2] = 1'b0; tl[2] = 1'b0;
    drain();
    check_order("t4", '{0}, 1'b0);

    // abort one cycle after the 2nd of 4 beats
    do_reset(1'b0);
    tv[0] = 1'b1; ta[0] = 15'h0400; tl[0] = 1'b0;
    wait_ready(0, t, ok);
    push_beat(0, 15'h0400, 1'b0, cyc + 1);
    @(posedge clk); #1;
    ta[0] = 15'h0401;
    wait_ready(0, t, ok);
    push_beat(0, 15'h0401, 1'b0, cyc + 1);
    @(posedge clk); #1;
    abort = 1'b1; ta[0] = 15'h0402;
    @(negedge clk);
    chk("abort_ready_low", 64'(req_ready), 64'd0);
    @(posedge clk); #1;
    abort = 1'b0; tv[0] = 1'b0;
    rsp_q.delete();
    @(negedge clk);
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_idle_ready", 64'(req_ready), 64'd0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("abort_no_rsp", 64'(rsp_valid), 64'd0);
    end
    @(posedge clk); #1;
    fork
      begin int w; drive_burst(1, 15'h0500, 1, -1, w); end
      begin int w; drive_burst(0, 15'h0510, 1, -1, w); end
    join
    drain();
    check_order("t5_after_abort", '{0, 1}, 1'b1);

    // latency-1 instance, full-width address 0x7FFF
    do_reset(1'b0);
    b_addr = {30'd0, 15'h7FFF}; b_last = 3'b001; b_valid = 3'b001;
    t = 0;
    do begin @(negedge clk); t++; end while (!b_ready[0] && t < 20);
    acc = cyc + 1;
    @(posedge clk); #1;
    b_valid = 3'b000; b_last = 3'b000;
    fi = 0; fr = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (b_mem_rd_en) begin
        fi++;
        chk("l1_rd_addr", 64'(b_mem_rd_addr), 64'h7FFF);
        chk("l1_rd_cycle", 64'(cyc), 64'(acc));
      end
      if (b_rsp_valid != 3'b000) begin
        fr++;
        chk("l1_rsp_valid", 64'(b_rsp_valid), 64'd1);
        chk("l1_rsp_last", 64'(b_rsp_last), 64'd1);
        chk("l1_rsp_data", b_rsp_data, mword(15'h7FFF));
        chk("l1_rsp_cycle", 64'(cyc), 64'(acc + 1));
      end
    end
    chk("l1_read_count", 64'(fi), 64'd1);
    chk("l1_rsp_count", 64'(fr), 64'd1);
    chk("l1_busy_end", 64'(b_busy), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/in_mem_rd_sched.md
Name: in_mem_rd_sched

Overview:
- Schedules the single input-memory read port among three burst requesters: conv 1x1 (idx 0), conv (idx 1), maxpool (idx 2).
- Each requester presents a burst of read addresses; the block grants whole bursts round-robin and drives the memory read enable and address.
- Returned data is steered back with a per-requester valid aligned to the BRAM read latency.
- Sits between the layer engines' address generators and the input memory wrapper; it replaces the static OPCODE mux.

Parameters:
- AXI_HP_BIT, 64, memory word width.
- ADDR_WIDTH, 14, address MSB index; addresses are ADDR_WIDTH+1 bits.
- RD_LATENCY, 2, cycles from mem_rd_en to valid mem_rd_data (legal 1..4).

Ports:
- clk  in  1  clock.
- rst_n  in  1  synchronous active-low reset.
- req_en_mask  in  3  requester enable; a 0 bit hides that requester from arbitration.
- abort  in  1  soft clear: terminate the current burst and drop in-flight data.
- req_valid  in  3  per-requester beat valid.
- req_addr  in  3*(ADDR_WIDTH+1)  packed beat addresses, requester i at slice i.
- req_last  in  3  final beat of the burst.
- req_ready  out  3  beat accepted when valid&ready.
- rsp_valid  out  3  per-requester read-data valid.
- rsp_last  out  3  response of the last beat.
- rsp_data  out  AXI_HP_BIT  read data, shared bus.
- mem_rd_en  out  1  to memory enb.
- mem_rd_addr  out  ADDR_WIDTH+1  to memory addrb.
- mem_rd_data  in  AXI_HP_BIT  from memory doutb.
- busy  out  1  burst granted or reads in flight.

Behaviour:
- Reset (rst_n=0 at a clk edge) forces:
  - state IDLE; grant cleared; last_grant=2 so requester 0 has first priority.
  - req_ready=0, mem_rd_en=0, mem_rd_addr=0, rsp_valid=0, rsp_last=0, busy=0.
  - latency pipeline cleared. rsp_data is don't-care while rsp_valid=0.
- FSM IDLE:
  - Candidates = req_valid & req_en_mask.
  - If any candidate exists, pick the first one in order last_grant+1, +2, +3 (mod 3), register it as grant, go to BURST.
  - req_ready=0 in IDLE, so there is one bubble cycle per burst.
- FSM BURST:
  - req_ready[grant]=1; all other ready bits are 0.
  - On a beat (valid&ready), the next cycle drives mem_rd_en=1 and mem_rd_addr=the addressed slice; otherwise mem_rd_en=0 and mem_rd_addr holds its value.
  - On a beat with req_last: last_grant=grant, return to IDLE.
  - The beat is issued normally; the next burst can start being arbitrated in the following cycle.
- Latency: a tag {valid, id[1:0], last} shifts through a RD_LATENCY-deep pipeline starting at mem_rd_en.
  - rsp_valid[id] and rsp_last[id] are registered outputs that assert together with mem_rd_data. rsp_data = mem_rd_data, combinational pass-through.
  - Accept-to-rsp_valid = 1+RD_LATENCY cycles (3 at default).
  - No response backpressure: consumers must sink every beat.
- Throughput: one beat per cycle inside a burst; bursts from different requesters never interleave.
- Mask changes mid-burst do not interrupt the granted burst; the new mask applies at the next arbitration.
- A requester dropping req_valid mid-burst stalls the burst; the grant is held with no timeout.
- abort: takes priority over everything except reset. In the same edge:
  - state goes to IDLE, all tags are invalidated, and mem_rd_en goes to 0.
  - last_grant is unchanged.
  - A beat presented in the abort cycle is not accepted (req_ready=0 while abort=1).
- busy = (state==BURST) | any tag valid.

Optional Feature:
- INMEM_RD_PERF_EN defined: adds outputs perf_beats (3x32, packed) and perf_stall (3x32, packed).
  - perf_beats[i] increments on each accepted beat of requester i.
  - perf_stall[i] increments each cycle req_valid[i]&req_en_mask[i]&!req_ready[i].
  - Counters saturate at all-ones and clear on reset or on the perf_clr input (1 bit, added with the macro).
- Not defined: these ports and counters are absent; all other behaviour is identical.

Decomposition:
- Shared package holds:
  - requester index constants REQ_C1=0, REQ_C=1, REQ_MP=2, and NUM_REQ=3;
  - the FSM state encoding (IDLE, BURST);
  - the response tag struct {valid, id, last}.
- One sub-module is natural: in_mem_rd_lat_pipe, a parameterised RD_LATENCY-deep tag shift register with a synchronous flush.

Test Plan:
- Reset then only req_valid[1]=1, 4-beat burst at addr 0x0010..0x0013 -> req_ready[1] rises 1 cycle later; mem_rd_addr 0x0010..0x0013 on consecutive cycles; rsp_valid[1] 3 cycles after each accept; rsp_last[1] on the 0x0013 response.
- All three requesting continuously with 2-beat bursts -> grant order 0,1,2,0,1,2; one idle cycle between bursts; no other ready bit asserted during a burst.
- req_en_mask=3'b101 with all valid -> requester 1 never granted; order alternates 0,2.
- Mid-burst req_valid[0] low for 3 cycles -> mem_rd_en=0 for those cycles; grant held; burst resumes; other requesters not granted.
- abort asserted one cycle after the 2nd of 4 beats -> state IDLE next cycle; no rsp_valid for the in-flight beats; busy=0; next arbitration starts after last_grant.
- RD_LATENCY=1 build, single 1-beat burst addr 0x7FFF -> rsp_valid 2 cycles after accept; mem_rd_addr=0x7FFF (full 15-bit width).
